// File: rtl/sym_output_ctrl_if.sv
// Handshake/bus bundle for sym_output_ctrl: lookup control in, FIFO head and status out.
interface sym_output_ctrl_if #(
    parameter int SYM_W = 8,
    parameter int CNT_W = 16
);
    logic             chsent;
    logic [SYM_W-1:0] sym_in;
    logic             clr_err;
    logic             out_ready;
    logic             out_valid;
    logic [SYM_W-1:0] out_data;
    logic             busy;
    logic             full;
    logic             done;
    logic             dict_error;
    logic [CNT_W-1:0] sym_count;

    modport master (
        output chsent, sym_in, clr_err, out_ready,
        input  out_valid, out_data, busy, full, done, dict_error, sym_count
    );
    modport slave (
        input  chsent, sym_in, clr_err, out_ready,
        output out_valid, out_data, busy, full, done, dict_error, sym_count
    );
endinterface

// File: rtl/sym_output_ctrl.sv
// Dictionary lookup sequencer feeding a small symbol FIFO; optional saturating
// push counter enabled by macro SYM_OUTPUT_CTRL_SYMCNT_EN.
module sym_output_ctrl #(
    parameter int SYM_W      = 8,
    parameter int LOOKUP_LAT = 2,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 16
) (
    input logic               clk,
    input logic               n_rst,
    sym_output_ctrl_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] WAIT = 3'd1;
    localparam logic [2:0] LOAD = 3'd2;
    localparam logic [2:0] HOLD = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;

    logic [2:0]       state;
    logic [2:0]       wait_cnt;
    logic [SYM_W-1:0] hold_q;
    logic [SYM_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             done_q;

    logic             pop, push, push_ok;
    logic [SYM_W-1:0] push_data;

    assign pop     = (count != '0) && bus.out_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = (count < DEPTH_C) || pop;

    always_comb begin
        push      = 1'b0;
        push_data = bus.sym_in;
        case (state)
            LOAD: push = (bus.sym_in != '0) && push_ok;
            HOLD: begin
                push      = push_ok;
                push_data = hold_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            hold_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= push;
            case (state)
                IDLE: if (bus.chsent) begin
                    state    <= WAIT;
                    wait_cnt <= 3'(LOOKUP_LAT);
                end
                WAIT: begin
                    if (wait_cnt == 3'd1) state <= LOAD;
                    wait_cnt <= wait_cnt - 3'd1;
                end
                LOAD: begin
                    hold_q <= bus.sym_in;
                    if (bus.sym_in == '0) state <= ERR;
                    else if (push)        state <= IDLE;
                    else                  state <= HOLD;
                end
                HOLD: if (push) state <= IDLE;
                ERR: begin
                    if (bus.chsent) begin
                        state    <= WAIT;
                        wait_cnt <= 3'(LOOKUP_LAT);
                    end else if (bus.clr_err) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    assign bus.out_valid  = (count != '0);
    // Head is gated so stale storage never shows after reset or drain.
    assign bus.out_data   = bus.out_valid ? mem[rd_ptr] : '0;
    assign bus.full       = (count == DEPTH_C);
    assign bus.busy       = (state == WAIT) || (state == LOAD) || (state == HOLD);
    assign bus.done       = done_q;
    assign bus.dict_error = (state == ERR);

`ifdef SYM_OUTPUT_CTRL_SYMCNT_EN
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (!n_rst)                    cnt_q <= '0;
        else if (push && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
    end
    assign bus.sym_count = cnt_q;
`else
    assign bus.sym_count = '0;
`endif

endmodule
